nn_infer_seq: RTL and testbench
===============================

# nn_infer_seq

Inference sequencer for the accelerator core. Once the CPU has loaded the weight SRAMs, bias and image through the CPU interface, this block runs one inference pass. It drives the shared read address to the image SRAM and all 46 weight SRAMs, and issues the clear, accumulate, bias-add and result-latch strobes to the 46 MAC lanes. It reports BUSY and DONE back to the CPU interface.

## Interface
- ADR_W, 10: width of the SRAM read address and of N_LEN.
- RD_LAT, 1: SRAM read latency in cycles; legal range 1..4.

- CLK  in  1  clock, all logic on rising edge
- RESET_X  in  1  asynchronous, active-low reset
- START  in  1  run request; accepted only in IDLE
- ABORT  in  1  cancel current run; sampled every cycle
- N_LEN  in  ADR_W  number of input elements; sampled when START is accepted
- MEM_RD  out  1  read strobe to the image SRAM and the weight SRAMs
- MEM_ADR  out  ADR_W  shared read address
- MAC_CLR  out  1  one-cycle clear of all 46 accumulators
- MAC_EN  out  1  accumulate; high exactly when read data is valid
- BIAS_EN  out  1  one-cycle bias add
- RESULT_LATCH  out  1  one-cycle load of the RESULT_0..45 registers
- BUSY  out  1  run in progress; CPU SRAM writes are blocked while high
- DONE  out  1  one-cycle completion pulse

## Operation
- All outputs are registered.
- Reset value of every output is 0, including MEM_ADR. The state machine resets to IDLE.
- States: IDLE, CLEAR, ACCUM, DRAIN, BIAS, LATCH, FIN.
- IDLE -> CLEAR when START=1 and ABORT=0. N_LEN is captured into the length register at this transition.
- CLEAR: MAC_CLR=1 for one cycle. Next state is ACCUM if the captured length is non-zero, otherwise BIAS.
- ACCUM:
  - MEM_RD=1 and MEM_ADR counts 0,1,...,len-1, one address per cycle.
  - Leave ACCUM after the cycle that issues address len-1.
  - Next state is DRAIN.
- DRAIN: lasts RD_LAT cycles. MEM_RD=0, and MEM_ADR holds its last value.
- BIAS: BIAS_EN=1 for one cycle.
- LATCH: RESULT_LATCH=1 for one cycle.
- FIN: DONE=1 for one cycle, BUSY=0. Next state is IDLE.
- MAC_EN is MEM_RD delayed by RD_LAT cycles through a shift register.
- BUSY=1 in CLEAR, ACCUM, DRAIN, BIAS and LATCH.
- Address counter is ADR_W bits wide.
  - N_LEN = 2^ADR_W-1 issues addresses 0..2^ADR_W-2.
  - The counter never wraps within a run.
  - MEM_ADR returns to 0 on entry to CLEAR.
- ABORT=1 in any state:
  - Next cycle the state is IDLE.
  - MEM_RD, MAC_EN (shift register flushed), MAC_CLR, BIAS_EN, RESULT_LATCH and BUSY are all 0.
  - DONE is not pulsed.
- ABORT and START high in the same IDLE cycle: ABORT wins and no run starts.
- START while not in IDLE (FIN included) is ignored; it is not queued.
- N_LEN changes during a run have no effect.
- RESET_X low mid-run: immediate return to IDLE with all outputs 0, independent of CLK.

## Timing
- Cycle 0 is the cycle in which START is sampled high. Let N be the captured length and L = RD_LAT.
- Cycle 1: CLEAR, MAC_CLR=1, BUSY=1.
- Cycles 2..N+1: ACCUM, MEM_RD=1, MEM_ADR = cycle-2.
- Cycles 2+L..N+1+L: MAC_EN=1.
- Cycles N+2..N+1+L: DRAIN.
- Cycle N+2+L: BIAS_EN=1.
- Cycle N+3+L: RESULT_LATCH=1.
- Cycle N+4+L: DONE=1, BUSY=0.
- Total run length for N>0 is N+4+L cycles. The next START is accepted from cycle N+5+L.
- N=0: CLEAR in cycle 1, BIAS_EN in cycle 2, RESULT_LATCH in cycle 3, DONE in cycle 4. MEM_RD and MAC_EN stay 0 throughout.
- The last MAC_EN cycle always precedes BIAS_EN by exactly one cycle.

## Test plan
- Basic run: RD_LAT=1, N_LEN=4, START in cycle 0 -> MAC_CLR in cycle 1; MEM_ADR 0..3 in cycles 2-5; MAC_EN in cycles 3-6; BIAS_EN in cycle 7; RESULT_LATCH in cycle 8; DONE in cycle 9; BUSY high in cycles 1-8.
- Latency sweep: RD_LAT=3, N_LEN=2 -> MAC_EN in cycles 5-6; BIAS_EN in cycle 7; DONE in cycle 9; MAC_EN pulse count equals N_LEN.
- Zero length: N_LEN=0 -> no MEM_RD and no MAC_EN; MAC_CLR in cycle 1, BIAS_EN in cycle 2, RESULT_LATCH in cycle 3, DONE in cycle 4.
- Abort mid-ACCUM: N_LEN=8, ABORT in cycle 4 -> from cycle 5 all outputs 0 and no DONE. A following START runs a full, correct pass.
- Conflicts: START with ABORT in IDLE -> no run. START pulsed in cycles 3 and 9 of the basic run -> both ignored, and the run timing is unchanged.
- Reset: RESET_X low in cycle 5 of the basic run -> outputs 0 asynchronously. After release, a START with N_LEN=1023 issues addresses 0..1022 with no wrap and DONE in cycle 1028.

Source files
------------

// File: rtl/nn_infer_seq.sv
`default_nettype none
// ============================================================================
// Module   : nn_infer_seq
// Purpose  : Inference sequencer. Sweeps the shared SRAM read address and
//            issues clear / accumulate / bias-add / result-latch strobes to
//            the MAC lanes for one inference pass, with BUSY/DONE status.
// Revision : 1.0  initial release
// ============================================================================
module nn_infer_seq #(
    parameter int ADR_W  = 10,
    parameter int RD_LAT = 1
) (
    input  logic             CLK,
    input  logic             RESET_X,
    input  logic             START,
    input  logic             ABORT,
    input  logic [ADR_W-1:0] N_LEN,
    output logic             MEM_RD,
    output logic [ADR_W-1:0] MEM_ADR,
    output logic             MAC_CLR,
    output logic             MAC_EN,
    output logic             BIAS_EN,
    output logic             RESULT_LATCH,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_BIAS  = 3'd4,
        S_LATCH = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    // Drain counter counts 0..RD_LAT-1; RD_LAT is at most 4, so 3 bits suffice.
    localparam logic [2:0] c_DRAIN_LAST = 3'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADR_W-1:0]  r_len;
    logic [ADR_W-1:0]  w_len_last;
    logic              w_adr_last;
    logic              w_drain_last;
    logic [2:0]        r_drain_cnt;
    logic [RD_LAT-1:0] r_rd_pipe;

    assign w_len_last   = r_len - ADR_W'(1);
    assign w_adr_last   = (MEM_ADR == w_len_last);
    assign w_drain_last = (r_drain_cnt == c_DRAIN_LAST);

    // Read data returns RD_LAT cycles after the strobe, so MAC_EN is the tap.
    assign MAC_EN = r_rd_pipe[RD_LAT-1];

    // State register.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; ABORT overrides everything, including START in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (ABORT) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (START) w_state_nxt = S_CLEAR;
                S_CLEAR: w_state_nxt = (r_len != '0) ? S_ACCUM : S_BIAS;
                S_ACCUM: if (w_adr_last) w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_drain_last) w_state_nxt = S_BIAS;
                S_BIAS:  w_state_nxt = S_LATCH;
                S_LATCH: w_state_nxt = S_FIN;
                S_FIN:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Registered strobes decoded from the upcoming state so they align with it.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            MEM_RD       <= 1'b0;
            MAC_CLR      <= 1'b0;
            BIAS_EN      <= 1'b0;
            RESULT_LATCH <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
        end else begin
            MEM_RD       <= (w_state_nxt == S_ACCUM);
            MAC_CLR      <= (w_state_nxt == S_CLEAR);
            BIAS_EN      <= (w_state_nxt == S_BIAS);
            RESULT_LATCH <= (w_state_nxt == S_LATCH);
            BUSY         <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_ACCUM) ||
                            (w_state_nxt == S_DRAIN) || (w_state_nxt == S_BIAS)  ||
                            (w_state_nxt == S_LATCH);
            DONE         <= (w_state_nxt == S_FIN);
        end
    end

    // Address counter: zeroed on entry to CLEAR, advances once per ACCUM cycle,
    // holds otherwise. It stops at len-1 so it never wraps within a run.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            MEM_ADR <= '0;
        end else if (w_state_nxt == S_CLEAR) begin
            MEM_ADR <= '0;
        end else if ((r_state == S_ACCUM) && (w_state_nxt == S_ACCUM)) begin
            MEM_ADR <= MEM_ADR + ADR_W'(1);
        end
    end

    // Length capture at run acceptance; later N_LEN changes are ignored.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            r_len <= '0;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_CLEAR)) begin
            r_len <= N_LEN;
        end
    end

    // Drain cycle counter, restarts whenever DRAIN is not active.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            r_drain_cnt <= '0;
        end else if (r_state == S_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + 3'd1;
        end else begin
            r_drain_cnt <= '0;
        end
    end

    // Read-valid shift register; flushed on ABORT so no stale MAC_EN escapes.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            r_rd_pipe <= '0;
        end else if (ABORT) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe <= RD_LAT'({r_rd_pipe, MEM_RD});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_infer_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nn_infer_seq
// Purpose  : Scoreboard bench for nn_infer_seq. Two instances (RD_LAT=1 and
//            RD_LAT=3) share the same stimulus; expected outputs per cycle are
//            derived from the run timing table and queued per instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_nn_infer_seq;

    localparam int AW = 10;

    logic          CLK     = 1'b0;
    logic          RESET_X = 1'b0;
    logic          START   = 1'b0;
    logic          ABORT   = 1'b0;
    logic [AW-1:0] N_LEN   = '0;

    logic          mem_rd_a, mac_clr_a, mac_en_a, bias_en_a, latch_a, busy_a, done_a;
    logic          mem_rd_b, mac_clr_b, mac_en_b, bias_en_b, latch_b, busy_b, done_b;
    logic [AW-1:0] adr_a, adr_b;
    logic [6:0]    ctl_a, ctl_b;

    assign ctl_a = {mem_rd_a, mac_clr_a, mac_en_a, bias_en_a, latch_a, busy_a, done_a};
    assign ctl_b = {mem_rd_b, mac_clr_b, mac_en_b, bias_en_b, latch_b, busy_b, done_b};

    always #5 CLK = ~CLK;

    nn_infer_seq #(.ADR_W(AW), .RD_LAT(1)) u_dut_l1 (
        .CLK(CLK), .RESET_X(RESET_X), .START(START), .ABORT(ABORT), .N_LEN(N_LEN),
        .MEM_RD(mem_rd_a), .MEM_ADR(adr_a), .MAC_CLR(mac_clr_a), .MAC_EN(mac_en_a),
        .BIAS_EN(bias_en_a), .RESULT_LATCH(latch_a), .BUSY(busy_a), .DONE(done_a)
    );

    nn_infer_seq #(.ADR_W(AW), .RD_LAT(3)) u_dut_l3 (
        .CLK(CLK), .RESET_X(RESET_X), .START(START), .ABORT(ABORT), .N_LEN(N_LEN),
        .MEM_RD(mem_rd_b), .MEM_ADR(adr_b), .MAC_CLR(mac_clr_b), .MAC_EN(mac_en_b),
        .BIAS_EN(bias_en_b), .RESULT_LATCH(latch_b), .BUSY(busy_b), .DONE(done_b)
    );

    // ctl order: {MEM_RD, MAC_CLR, MAC_EN, BIAS_EN, RESULT_LATCH, BUSY, DONE}
    typedef struct packed {
        logic          chk_adr;
        logic [AW-1:0] adr;
        logic [6:0]    ctl;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   vectors = 0;
    int   errors  = 0;

    // Per-instance run tracker: k is the cycle index relative to START (cycle 0).
    int   lat[2]   = '{1, 3};
    bit   act[2]   = '{0, 0};
    int   k[2]     = '{0, 0};
    int   n[2]     = '{0, 0};
    bit   fresh[2] = '{1, 1};

    function automatic int bias_cycle(int i);
        return (n[i] == 0) ? 2 : n[i] + 2 + lat[i];
    endfunction

    // Expected outputs for the current cycle, straight from the timing table.
    function automatic exp_t expect_lane(int i);
        exp_t e;
        int   kk;
        int   bk;
        int   nn;
        int   ll;
        e  = '0;
        kk = k[i];
        nn = n[i];
        ll = lat[i];
        if (act[i]) begin
            bk = bias_cycle(i);
            e.ctl[6] = (nn > 0) && (kk >= 2) && (kk <= nn + 1);
            e.ctl[5] = (kk == 1);
            e.ctl[4] = (nn > 0) && (kk >= 2 + ll) && (kk <= nn + 1 + ll);
            e.ctl[3] = (kk == bk);
            e.ctl[2] = (kk == bk + 1);
            e.ctl[1] = (kk <= bk + 1);
            e.ctl[0] = (kk == bk + 2);
            if ((nn > 0) && (kk >= 2) && (kk <= nn + 1 + ll)) begin
                e.chk_adr = 1'b1;
                e.adr     = (kk - 2 < nn - 1) ? AW'(kk - 2) : AW'(nn - 1);
            end
        end else if (fresh[i]) begin
            e.chk_adr = 1'b1;
            e.adr     = '0;
        end
        return e;
    endfunction

    task automatic check_lane(input int i, input exp_t e, input logic [6:0] c,
                              input logic [AW-1:0] a);
        vectors++;
        if (c !== e.ctl) begin
            errors++;
            $display("FAIL ctl L=%0d t=%0t got %b expected %b", lat[i], $time, c, e.ctl);
        end
        if (e.chk_adr) begin
            vectors++;
            if (a !== e.adr) begin
                errors++;
                $display("FAIL mem_adr L=%0d t=%0t got %0d expected %0d", lat[i], $time, a, e.adr);
            end
        end
    endtask

    // Monitor: one expected entry per instance per cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (q0.size() > 0) check_lane(0, q0.pop_front(), ctl_a, adr_a);
        if (q1.size() > 0) check_lane(1, q1.pop_front(), ctl_b, adr_b);
    end

    // Apply inputs for one cycle, then queue the expectation for the next one.
    task automatic tick(input bit st, input bit ab, input logic [AW-1:0] nl);
        bit prev;
        START = st;
        ABORT = ab;
        N_LEN = nl;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            prev = act[i];
            if (ab) begin
                act[i] = 1'b0;
            end else if (prev) begin
                k[i]++;
                if (k[i] > bias_cycle(i) + 2) act[i] = 1'b0;
            end else if (st) begin
                act[i]   = 1'b1;
                k[i]     = 1;
                n[i]     = int'(nl);
                fresh[i] = 1'b0;
            end
        end
        q0.push_back(expect_lane(0));
        q1.push_back(expect_lane(1));
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear with no edge.
    task automatic reset_mid();
        exp_t z;
        z         = '0;
        z.chk_adr = 1'b1;
        #1;
        RESET_X = 1'b0;
        START   = 1'b0;
        ABORT   = 1'b0;
        #1;
        check_lane(0, z, ctl_a, adr_a);
        check_lane(1, z, ctl_b, adr_b);
        for (int i = 0; i < 2; i++) begin
            act[i]   = 1'b0;
            fresh[i] = 1'b1;
        end
        void'(q0.pop_back());
        void'(q1.pop_back());
        q0.push_back(expect_lane(0));
        q1.push_back(expect_lane(1));
    endtask

    // Directed stimulus.
    initial begin
        exp_t z;
        z         = '0;
        z.chk_adr = 1'b1;
        #2;
        check_lane(0, z, ctl_a, adr_a);
        check_lane(1, z, ctl_b, adr_b);
        repeat (2) tick(1'b0, 1'b0, '0);
        RESET_X = 1'b1;
        repeat (2) tick(1'b0, 1'b0, '0);

        // Basic run N=4 with stray STARTs in cycles 3 and 9.
        tick(1'b1, 1'b0, 10'd4);
        for (int c = 1; c <= 14; c++) tick((c == 3) || (c == 9), 1'b0, 10'd9);
        repeat (2) tick(1'b0, 1'b0, '0);

        // Short run N=2, exercises the deeper read latency lane.
        tick(1'b1, 1'b0, 10'd2);
        repeat (12) tick(1'b0, 1'b0, 10'd2);

        // Zero length.
        tick(1'b1, 1'b0, 10'd0);
        repeat (7) tick(1'b0, 1'b0, 10'd0);

        // Abort mid-ACCUM in cycle 4, then a clean run.
        tick(1'b1, 1'b0, 10'd8);
        repeat (3) tick(1'b0, 1'b0, 10'd8);
        tick(1'b0, 1'b1, 10'd8);
        repeat (3) tick(1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 10'd3);
        repeat (13) tick(1'b0, 1'b0, 10'd3);

        // START and ABORT together in IDLE: nothing runs.
        tick(1'b1, 1'b1, 10'd5);
        repeat (5) tick(1'b0, 1'b0, 10'd5);

        // Reset in cycle 5 of a basic run, then a full-length run.
        tick(1'b1, 1'b0, 10'd4);
        repeat (4) tick(1'b0, 1'b0, 10'd4);
        reset_mid();
        repeat (2) tick(1'b0, 1'b0, '0);
        RESET_X = 1'b1;
        tick(1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 10'd1023);
        repeat (1035) tick(1'b0, 1'b0, 10'd17);
        repeat (3) tick(1'b0, 1'b0, '0);

        @(negedge CLK);
        #1;
        if ((q0.size() != 0) || (q1.size() != 0)) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d/%0d required 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
